// File: rtl/pipe_stage_regs_pkg.sv
// Shared constants for the MINI-RISC FD/DE/EW pipeline register bank:
// opcode encodings, forward-select codes and the saturating-counter helper
// used by the optional performance counters (PIPE_PERF_EN).
package pipe_stage_regs_pkg;

    // Opcode encodings carried in the upper five bits of the instruction word.
    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_LBH  = 5'd1,
        OP_LBL  = 5'd2,
        OP_SETF = 5'd3,
        OP_CPLF = 5'd4
    } opcode_e;

    // Forward-select codes; every other code falls back to the register-file value.
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_WB = 2'b10;

    // Width of each performance counter.
    localparam int PERF_W = 16;

    // True when the select asks for the writeback result.
    function automatic logic fwd_is_wb(input logic [1:0] sel);
        return (sel == FWD_WB);
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] val);
        if (val == {PERF_W{1'b1}}) begin
            return val;
        end else begin
            return val + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/pipe_reg_ctl.sv
// Generic valid + payload pipeline register. On each rising edge the
// priority is flush > stall > advance; a flush clears both valid and payload.
module pipe_reg_ctl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         flush,
    input  logic         valid_in,
    input  logic [W-1:0] data_in,
    output logic         valid_q,
    output logic [W-1:0] data_q
);

    logic         valid_d;
    logic [W-1:0] data_d;

    // Next-state selection: bubble on flush, hold on stall, otherwise load upstream.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = {W{1'b0}};
        end else if (stall) begin
            valid_d = valid_q;
            data_d  = data_q;
        end else begin
            valid_d = valid_in;
            data_d  = data_in;
        end
    end

    // State register; asynchronous reset clears valid and payload immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= {W{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pipe_stage_regs.sv
// FD, DE and EW pipeline registers for the MINI-RISC core, with the Execute
// operand-forwarding mux and the stall-time operand capture.
// Optional feature: define PIPE_PERF_EN to add stall/bubble/retired counters.
module pipe_stage_regs
    import pipe_stage_regs_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 16,
    parameter int PC_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr_F,
    input  logic [PC_W-1:0]    pc_F,
    input  logic               stall_F,
    input  logic               flush_F,
    input  logic               stall_D,
    input  logic               flush_D,
    input  logic               stall_E,
    input  logic               flush_E,
    input  logic [1:0]         forward_A,
    input  logic [1:0]         forward_B,
    input  logic [4:0]         opcode_D,
    input  logic [2:0]         rd_D,
    input  logic [2:0]         rs1_D,
    input  logic [2:0]         rs2_D,
    input  logic               reg_write_D,
    input  logic [DATA_W-1:0]  rf_a_D,
    input  logic [DATA_W-1:0]  rf_b_D,
    input  logic [DATA_W-1:0]  alu_res_E,
    output logic [INSTR_W-1:0] instr_D,
    output logic [PC_W-1:0]    pc_D,
    output logic               valid_D,
    output logic [4:0]         opcode_E,
    output logic [2:0]         rd_E,
    output logic [2:0]         rs1_E,
    output logic [2:0]         rs2_E,
    output logic               reg_write_E,
    output logic               valid_E,
    output logic [DATA_W-1:0]  op_a_E,
    output logic [DATA_W-1:0]  op_b_E,
`ifdef PIPE_PERF_EN
    output logic [PERF_W-1:0]  stall_cycles,
    output logic [PERF_W-1:0]  bubble_count,
    output logic [PERF_W-1:0]  retired,
`endif
    output logic [4:0]         opcode_W,
    output logic [2:0]         rd_W,
    output logic               reg_write_W,
    output logic [DATA_W-1:0]  result_W,
    output logic               valid_W
);

    localparam int FD_W = INSTR_W + PC_W;
    localparam int DE_W = 5 + 3 + 3 + 3 + 1;
    localparam int EW_W = 5 + 3 + 1 + DATA_W;

    logic [FD_W-1:0]   fd_data_q;
    logic [DE_W-1:0]   de_data_in_s;
    logic [DE_W-1:0]   de_data_q;
    logic [EW_W-1:0]   ew_data_in_s;
    logic [EW_W-1:0]   ew_data_q;
    logic [DATA_W-1:0] op_a_d;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_d;
    logic [DATA_W-1:0] op_b_q;

    // FD: every fetched word enters as valid; flush_F turns it into a bubble.
    pipe_reg_ctl #(.W(FD_W)) u_fd (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall_F),
        .flush    (flush_F),
        .valid_in (1'b1),
        .data_in  ({instr_F, pc_F}),
        .valid_q  (valid_D),
        .data_q   (fd_data_q)
    );

    assign instr_D = fd_data_q[FD_W-1:PC_W];
    assign pc_D    = fd_data_q[PC_W-1:0];

    // The write enable is stored pre-gated so reg_write_E can never be set on a bubble.
    assign de_data_in_s = {opcode_D, rd_D, rs1_D, rs2_D, reg_write_D & valid_D};

    pipe_reg_ctl #(.W(DE_W)) u_de (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall_D),
        .flush    (flush_D),
        .valid_in (valid_D),
        .data_in  (de_data_in_s),
        .valid_q  (valid_E),
        .data_q   (de_data_q)
    );

    assign opcode_E    = de_data_q[14:10];
    assign rd_E        = de_data_q[9:7];
    assign rs1_E       = de_data_q[6:4];
    assign rs2_E       = de_data_q[3:1];
    assign reg_write_E = de_data_q[0];

    assign ew_data_in_s = {opcode_E, rd_E, reg_write_E & valid_E, alu_res_E};

    pipe_reg_ctl #(.W(EW_W)) u_ew (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall_E),
        .flush    (flush_E),
        .valid_in (valid_E),
        .data_in  (ew_data_in_s),
        .valid_q  (valid_W),
        .data_q   (ew_data_q)
    );

    assign opcode_W    = ew_data_q[EW_W-1:EW_W-5];
    assign rd_W        = ew_data_q[EW_W-6:EW_W-8];
    assign reg_write_W = ew_data_q[DATA_W];
    assign result_W    = ew_data_q[DATA_W-1:0];

    // DE operand latches: load RF data on advance; while stalled, grab result_W when
    // it is being forwarded so the value survives EW advancing or bubbling.
    always_comb begin
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        if (flush_D) begin
            op_a_d = {DATA_W{1'b0}};
            op_b_d = {DATA_W{1'b0}};
        end else if (stall_D) begin
            if (fwd_is_wb(forward_A)) begin
                op_a_d = result_W;
            end else begin
                op_a_d = op_a_q;
            end
            if (fwd_is_wb(forward_B)) begin
                op_b_d = result_W;
            end else begin
                op_b_d = op_b_q;
            end
        end else begin
            op_a_d = rf_a_D;
            op_b_d = rf_b_D;
        end
    end

    // Operand latch registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q <= {DATA_W{1'b0}};
            op_b_q <= {DATA_W{1'b0}};
        end else begin
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
        end
    end

    // Execute-stage forwarding mux; reserved and unused codes select the latched value.
    assign op_a_E = fwd_is_wb(forward_A) ? result_W : op_a_q;
    assign op_b_E = fwd_is_wb(forward_B) ? result_W : op_b_q;

`ifdef PIPE_PERF_EN
    logic              any_stall_s;
    logic              any_flush_s;
    logic [PERF_W-1:0] stall_cycles_d;
    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] bubble_count_d;
    logic [PERF_W-1:0] bubble_count_q;
    logic [PERF_W-1:0] retired_d;
    logic [PERF_W-1:0] retired_q;

    assign any_stall_s = stall_F | stall_D | stall_E;
    assign any_flush_s = flush_F | flush_D | flush_E;

    // Counter next-state: a cycle with any flush is a bubble, not a stall.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        bubble_count_d = bubble_count_q;
        retired_d      = retired_q;
        if (any_flush_s) begin
            bubble_count_d = sat_inc(bubble_count_q);
        end else if (any_stall_s) begin
            stall_cycles_d = sat_inc(stall_cycles_q);
        end else begin
            bubble_count_d = bubble_count_q;
        end
        if (valid_W) begin
            retired_d = sat_inc(retired_q);
        end else begin
            retired_d = retired_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= {PERF_W{1'b0}};
            bubble_count_q <= {PERF_W{1'b0}};
            retired_q      <= {PERF_W{1'b0}};
        end else begin
            stall_cycles_q <= stall_cycles_d;
            bubble_count_q <= bubble_count_d;
            retired_q      <= retired_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign bubble_count = bubble_count_q;
    assign retired      = retired_q;
`endif

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed self-checking bench for pipe_stage_regs. A tiny decoder model turns
// instr_D into the decoder fields; the ALU result is {A0, rd_E} unless overridden.
// The counter section is compiled only when PIPE_PERF_EN is defined.
module tb_pipe_stage_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr_F;
    logic [7:0]  pc_F;
    logic        stall_F, flush_F, stall_D, flush_D, stall_E, flush_E;
    logic [1:0]  forward_A, forward_B;
    logic [4:0]  opcode_D;
    logic [2:0]  rd_D, rs1_D, rs2_D;
    logic        reg_write_D;
    logic [15:0] rf_a_D, rf_b_D, alu_res_E;
    logic [15:0] instr_D;
    logic [7:0]  pc_D;
    logic        valid_D;
    logic [4:0]  opcode_E;
    logic [2:0]  rd_E, rs1_E, rs2_E;
    logic        reg_write_E, valid_E;
    logic [15:0] op_a_E, op_b_E;
    logic [4:0]  opcode_W;
    logic [2:0]  rd_W;
    logic        reg_write_W;
    logic [15:0] result_W;
    logic        valid_W;
`ifdef PIPE_PERF_EN
    logic [15:0] stall_cycles, bubble_count, retired;
`endif

    logic        alu_ovr;
    logic [15:0] alu_val;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    // Decoder / register-file / ALU stand-ins.
    assign opcode_D    = instr_D[15:11];
    assign rd_D        = instr_D[10:8];
    assign rs1_D       = instr_D[7:5];
    assign rs2_D       = instr_D[4:2];
    assign reg_write_D = 1'b1;
    assign rf_a_D      = {pc_D, 8'hA0};
    assign rf_b_D      = {pc_D, 8'hB0};
    assign alu_res_E   = alu_ovr ? alu_val : {13'h1400, rd_E};

    pipe_stage_regs dut (
        .clk(clk), .rst_n(rst_n), .instr_F(instr_F), .pc_F(pc_F),
        .stall_F(stall_F), .flush_F(flush_F), .stall_D(stall_D), .flush_D(flush_D),
        .stall_E(stall_E), .flush_E(flush_E), .forward_A(forward_A), .forward_B(forward_B),
        .opcode_D(opcode_D), .rd_D(rd_D), .rs1_D(rs1_D), .rs2_D(rs2_D),
        .reg_write_D(reg_write_D), .rf_a_D(rf_a_D), .rf_b_D(rf_b_D), .alu_res_E(alu_res_E),
        .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D),
        .opcode_E(opcode_E), .rd_E(rd_E), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .reg_write_E(reg_write_E), .valid_E(valid_E), .op_a_E(op_a_E), .op_b_E(op_b_E),
`ifdef PIPE_PERF_EN
        .stall_cycles(stall_cycles), .bubble_count(bubble_count), .retired(retired),
`endif
        .opcode_W(opcode_W), .rd_W(rd_W), .reg_write_W(reg_write_W),
        .result_W(result_W), .valid_W(valid_W)
    );

    function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; instr_F = 16'h0000; pc_F = 8'h00;
        stall_F = 1'b0; flush_F = 1'b0; stall_D = 1'b0; flush_D = 1'b0;
        stall_E = 1'b0; flush_E = 1'b0; forward_A = 2'b00; forward_B = 2'b00;
        alu_ovr = 1'b0; alu_val = 16'h0000;
        tick(); tick();
        // Reset state
        chk("rst_valid_D", {31'd0, valid_D}, 32'd0);
        chk("rst_valid_E", {31'd0, valid_E}, 32'd0);
        chk("rst_valid_W", {31'd0, valid_W}, 32'd0);
        chk("rst_rw_W", {31'd0, reg_write_W}, 32'd0);
        chk("rst_instr_D", {16'd0, instr_D}, 32'd0);
        chk("rst_result_W", {16'd0, result_W}, 32'd0);
        chk("rst_op_a_E", {16'd0, op_a_E}, 32'd0);

        // Advance: four instructions, no hazards
        rst_n = 1'b1;
        instr_F = mk(5'd1, 3'd1, 3'd2, 3'd3); pc_F = 8'h10; tick();
        chk("adv_valid_D", {31'd0, valid_D}, 32'd1);
        chk("adv_instr_D", {16'd0, instr_D}, {16'd0, mk(5'd1, 3'd1, 3'd2, 3'd3)});
        chk("adv_pc_D", {24'd0, pc_D}, 32'h10);
        chk("adv_valid_E0", {31'd0, valid_E}, 32'd0);
        instr_F = mk(5'd2, 3'd2, 3'd1, 3'd1); pc_F = 8'h11; tick();
        chk("adv_valid_E", {31'd0, valid_E}, 32'd1);
        chk("adv_rd_E", {29'd0, rd_E}, 32'd1);
        chk("adv_rw_E", {31'd0, reg_write_E}, 32'd1);
        chk("adv_valid_W0", {31'd0, valid_W}, 32'd0);
        instr_F = mk(5'd3, 3'd3, 3'd1, 3'd2); pc_F = 8'h12; tick();
        chk("adv_valid_W", {31'd0, valid_W}, 32'd1);
        chk("adv_rd_W1", {29'd0, rd_W}, 32'd1);
        chk("adv_res_W1", {16'd0, result_W}, 32'hA001);
        chk("adv_rw_W", {31'd0, reg_write_W}, 32'd1);
        chk("adv_op_W", {27'd0, opcode_W}, 32'd1);
        instr_F = mk(5'd4, 3'd4, 3'd3, 3'd3); pc_F = 8'h13; tick();
        chk("adv_rd_W2", {29'd0, rd_W}, 32'd2);
        instr_F = mk(5'd5, 3'd5, 3'd4, 3'd4); pc_F = 8'h14; tick();
        chk("adv_rd_W3", {29'd0, rd_W}, 32'd3);
        tick();
        chk("adv_rd_W4", {29'd0, rd_W}, 32'd4);
        chk("adv_res_W4", {16'd0, result_W}, 32'hA004);

        // Mid-stream asynchronous reset, checked before any clock edge
        chk("pre_rst_valid_E", {31'd0, valid_E}, 32'd1);
        rst_n = 1'b0; #2;
        chk("arst_valid_D", {31'd0, valid_D}, 32'd0);
        chk("arst_valid_E", {31'd0, valid_E}, 32'd0);
        chk("arst_valid_W", {31'd0, valid_W}, 32'd0);
        chk("arst_rw_W", {31'd0, reg_write_W}, 32'd0);
        chk("arst_result_W", {16'd0, result_W}, 32'd0);
        chk("arst_rd_W", {29'd0, rd_W}, 32'd0);
        tick();
        rst_n = 1'b1;
        instr_F = mk(5'd6, 3'd6, 3'd0, 3'd0); pc_F = 8'h20; tick();
        instr_F = mk(5'd7, 3'd7, 3'd0, 3'd0); pc_F = 8'h21; tick();
        chk("post_rst_valid_W0", {31'd0, valid_W}, 32'd0);
        instr_F = mk(5'd1, 3'd2, 3'd0, 3'd0); pc_F = 8'h22; tick();
        chk("post_rst_valid_W", {31'd0, valid_W}, 32'd1);
        chk("post_rst_rd_W", {29'd0, rd_W}, 32'd6);

        // Branch: stall everywhere plus flush F/D; flush wins, EW holds
        stall_F = 1'b1; stall_D = 1'b1; stall_E = 1'b1; flush_F = 1'b1; flush_D = 1'b1;
        tick();
        stall_F = 1'b0; stall_D = 1'b0; stall_E = 1'b0; flush_F = 1'b0; flush_D = 1'b0;
        chk("br_valid_D", {31'd0, valid_D}, 32'd0);
        chk("br_valid_E", {31'd0, valid_E}, 32'd0);
        chk("br_rw_E", {31'd0, reg_write_E}, 32'd0);
        chk("br_instr_D", {16'd0, instr_D}, 32'd0);
        chk("br_valid_W", {31'd0, valid_W}, 32'd1);
        chk("br_rd_W", {29'd0, rd_W}, 32'd6);
        chk("br_res_W", {16'd0, result_W}, 32'hA006);

        // Forward: X (rd=3, result 00A5) in W, Y (rs1=3) in E
        instr_F = mk(5'd2, 3'd3, 3'd0, 3'd0); pc_F = 8'h30; tick();
        instr_F = mk(5'd3, 3'd1, 3'd3, 3'd4); pc_F = 8'h31; tick();
        alu_ovr = 1'b1; alu_val = 16'h00A5;
        instr_F = mk(5'd4, 3'd5, 3'd0, 3'd0); pc_F = 8'h32; tick();
        alu_ovr = 1'b0;
        chk("fwd_rd_W", {29'd0, rd_W}, 32'd3);
        chk("fwd_rw_W", {31'd0, reg_write_W}, 32'd1);
        chk("fwd_rs1_E", {29'd0, rs1_E}, 32'd3);
        forward_A = 2'b10; #1;
        chk("fwd_a_wb", {16'd0, op_a_E}, 32'h00A5);
        forward_A = 2'b00; #1;
        chk("fwd_a_rf", {16'd0, op_a_E}, 32'h31A0);
        forward_A = 2'b01; #1;
        chk("fwd_a_01", {16'd0, op_a_E}, 32'h31A0);
        forward_A = 2'b11; #1;
        chk("fwd_a_11", {16'd0, op_a_E}, 32'h31A0);
        chk("fwd_b_rf", {16'd0, op_b_E}, 32'h31B0);
        forward_A = 2'b00;

        // Capture: Y (result 1234) in W, DE stalled with forward_B=10, then EW flush
        alu_ovr = 1'b1; alu_val = 16'h1234;
        instr_F = mk(5'd5, 3'd6, 3'd0, 3'd0); pc_F = 8'h33; tick();
        alu_ovr = 1'b0;
        stall_F = 1'b1; stall_D = 1'b1; forward_B = 2'b10; #1;
        chk("cap_b_live", {16'd0, op_b_E}, 32'h1234);
        tick();
        forward_B = 2'b00; flush_E = 1'b1; #1;
        chk("cap_res_W_moved", {16'd0, result_W}, 32'hA005);
        chk("cap_b_held1", {16'd0, op_b_E}, 32'h1234);
        tick();
        chk("cap_valid_W", {31'd0, valid_W}, 32'd0);
        chk("cap_res_W_flush", {16'd0, result_W}, 32'd0);
        chk("cap_b_held2", {16'd0, op_b_E}, 32'h1234);
        chk("cap_rd_E_held", {29'd0, rd_E}, 32'd5);
        stall_F = 1'b0; stall_D = 1'b0; flush_E = 1'b0; tick();
        chk("cap_b_adv", {16'd0, op_b_E}, 32'h33B0);
        chk("cap_rd_E_adv", {29'd0, rd_E}, 32'd6);

`ifdef PIPE_PERF_EN
        // Performance counters
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("perf_rst_stall", {16'd0, stall_cycles}, 32'd0);
        chk("perf_rst_bubble", {16'd0, bubble_count}, 32'd0);
        stall_D = 1'b1;
        repeat (5) tick();
        stall_D = 1'b0; flush_E = 1'b1; stall_E = 1'b1;
        repeat (2) tick();
        flush_E = 1'b0; stall_E = 1'b0;
        chk("perf_stall", {16'd0, stall_cycles}, 32'd5);
        chk("perf_bubble", {16'd0, bubble_count}, 32'd2);
        stall_F = 1'b1;
        repeat (65540) tick();
        stall_F = 1'b0;
        chk("perf_stall_sat", {16'd0, stall_cycles}, 32'hFFFF);
        chk("perf_bubble_hold", {16'd0, bubble_count}, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
